dbg_state_log_sched: RTL
========================

# dbg_state_log_sched

Round-robin readout scheduler for a bank of state-history loggers. Each logger holds a current state plus three previous states and raises a sticky change flag. This block picks one flagged logger and freezes it. It streams that logger's four-entry history out over a valid/ready word interface, then clears the logger. It sits between the per-rail/per-FSM debug loggers and the host-visible debug register/mailbox path.

## Interface
- NUM_LOG, 4, number of loggers served (2..16)
- BITS, 8, width of one logged state word
- TW, $clog2(NUM_LOG), width of oTag
- iClk  in  1  clock
- iRst_n  in  1  reset, asynchronous, active-low
- iChange  in  NUM_LOG  per-logger sticky change flag
- iSnap  in  NUM_LOG*4*BITS  logger i at [i*4*BITS +: 4*BITS]; word j at [j*BITS +: BITS]; j=0 current, 1 prev_state_2, 2 prev_state_1, 3 prev_state (oldest)
- iFreeze  in  1  host hold: no new grant while high
- iReady  in  1  sink accepts oData this cycle
- oEnable  out  NUM_LOG  per-logger capture enable
- oClear_n  out  NUM_LOG  per-logger clear, active-low, one-cycle pulse
- oData  out  BITS  history word being offered
- oTag  out  TW  index of logger being read
- oValid  out  1  oData/oTag valid
- oBusy  out  1  service in progress (state != IDLE)

## Operation
- FSM states: IDLE, SEND, CLEAR, HOLD.
- IDLE: if (|iChange) && !iFreeze, grant g = first set iChange index searching ptr, ptr+1, …, wrapping mod NUM_LOG.
  - Same edge: latch g into oTag, latch logger g's 4 words into a snapshot register, set word counter wc=0, drop oEnable[g], go to SEND.
- SEND: oValid=1, oData=snapshot[wc].
  - On oValid&&iReady: wc++. Acceptance with wc=3 goes to CLEAR with oValid=0.
  - oData/oTag stay stable while oValid && !iReady.
- CLEAR: oClear_n[g]=0 for exactly one cycle, then HOLD.
- HOLD: one cycle so logger g's flag deassertion is visible. Then restore oEnable[g]=1, set ptr=(g+1) mod NUM_LOG, go to IDLE.
- Words leave newest first: current, prev_state_2, prev_state_1, prev_state.
- Only logger g is frozen or cleared. All other loggers keep oEnable=1 and keep capturing, and their flags wait for later grants.
- iFreeze affects only the grant decision in IDLE. A service already started always completes.
- iChange bits that rise or fall while not in IDLE have no effect until the next IDLE evaluation.
- Snapshot is taken from iSnap at grant. Later iSnap changes of g are ignored (g is frozen anyway).
- At most one oClear_n bit is low at any time. oClear_n is never low outside CLEAR.

## Timing
- Reset values: state IDLE, ptr 0, wc 0, oEnable all 1, oClear_n all 1, oValid 0, oData 0, oTag 0, oBusy 0, snapshot 0.
- Grant latency: iChange sampled set in IDLE at edge k gives oValid=1 and oBusy=1 in cycle k+1.
- Best-case service with iReady held high is 6 cycles grant-to-IDLE: 4 SEND, 1 CLEAR, 1 HOLD. The next grant can be made in the IDLE cycle that follows.
- Each iReady stall cycle extends SEND by one cycle.
- All outputs are registered, with no combinational path from iReady or iChange to any output.
- Reset asserted mid-service: immediate return to reset values. oEnable goes all 1 and no clear pulse is issued. The interrupted history is not re-sent, and loggers rely on their own reset.
- NUM_LOG=1: ptr stays 0, and the behaviour is otherwise identical.

## Test plan
- Single event: NUM_LOG=4, BITS=8, iReady=1, iChange=0100, logger 2 words 0x11,0x22,0x33,0x44 → oTag=2, oData 0x11,0x22,0x33,0x44 on 4 consecutive cycles, oClear_n=1011 for one cycle, oEnable[2]=0 for 6 cycles, ptr=3.
- Round-robin fairness: iChange held 1111, clears ignored (flags stay set) → grant order 0,1,2,3,0; every grant is followed by a new grant one IDLE cycle after HOLD.
- Backpressure: iReady low for 3 cycles on word 1 → oData holds word 1 and oValid stays 1 throughout; total service is 9 cycles; no word is dropped or duplicated.
- Freeze: iFreeze=1 with iChange=0001 → no grant and oEnable stays all 1. Assert iFreeze during SEND → the transfer completes. Release iFreeze in IDLE → the next grant follows one cycle later.
- Mid-service reset: assert iRst_n low during SEND wc=2 → all outputs return to their reset values immediately. After release, the still-set flag causes the logger to be re-granted, starting again at wc=0.
- Wrap grant: ptr=3, iChange=0011 → logger 0 is served first, then logger 1.

Source files
------------

// File: rtl/dbg_state_log_sched.sv
// dbg_state_log_sched: round-robin readout scheduler for a bank of state-history loggers
// Picks a flagged logger, freezes it, streams its four history words newest first, then clears it.
// Ports:
//   iClk, iRst_n          clock, asynchronous active-low reset
//   iChange[NUM_LOG]      per-logger sticky change flags
//   iSnap                 logger i at [i*4*BITS +: 4*BITS], word j at [j*BITS +: BITS], word 0 newest
//   iFreeze               blocks new grants while high
//   iReady                sink accepts oData this cycle
//   oEnable[NUM_LOG]      per-logger capture enable, low only for the logger in service
//   oClear_n[NUM_LOG]     per-logger one-cycle active-low clear
//   oData, oTag, oValid   offered history word, logger index, valid
//   oBusy                 service in progress
module dbg_state_log_sched #(
  parameter int NUM_LOG = 4,
  parameter int BITS = 8,
  parameter int TW = (NUM_LOG > 1) ? $clog2(NUM_LOG) : 1
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic [NUM_LOG-1:0]        iChange,
  input  logic [NUM_LOG*4*BITS-1:0] iSnap,
  input  logic                      iFreeze,
  input  logic                      iReady,
  output logic [NUM_LOG-1:0]        oEnable,
  output logic [NUM_LOG-1:0]        oClear_n,
  output logic [BITS-1:0]           oData,
  output logic [TW-1:0]             oTag,
  output logic                      oValid,
  output logic                      oBusy
);
  typedef enum logic [1:0] {IDLE, SEND, CLEAR, HOLD} state_t;
  state_t state, state_n;
  logic [TW-1:0] ptr, ptr_n, tag_n, g;
  logic [TW:0] sum;
  logic [1:0] wc, wc_n;
  logic [4*BITS-1:0] snap, snap_n;
  logic [NUM_LOG-1:0] en_n, clr_n;
  logic [BITS-1:0] data_n;
  logic valid_n, busy_n, found;
  // first set flag at or after ptr, wrapping; sum carries one extra bit so the wrap compare never overflows
  always_comb begin
    found = 1'b0;
    g = '0;
    sum = '0;
    for (int k = 0; k < NUM_LOG; k++) begin
      sum = {1'b0, ptr} + (TW+1)'(k);
      sum = (sum >= (TW+1)'(NUM_LOG)) ? sum - (TW+1)'(NUM_LOG) : sum;
      if (!found && iChange[sum[TW-1:0]]) begin
        found = 1'b1;
        g = sum[TW-1:0];
      end
    end
  end
  // every output is computed here one cycle ahead and registered below
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    wc_n = wc;
    snap_n = snap;
    en_n = oEnable;
    clr_n = oClear_n;
    data_n = oData;
    tag_n = oTag;
    valid_n = oValid;
    busy_n = oBusy;
    unique case (state)
      IDLE: if (found && !iFreeze) begin
        state_n = SEND;
        tag_n = g;
        snap_n = iSnap[g*4*BITS +: 4*BITS];
        data_n = iSnap[g*4*BITS +: BITS];
        wc_n = 2'd0;
        en_n[g] = 1'b0;
        valid_n = 1'b1;
        busy_n = 1'b1;
      end
      SEND: if (iReady) begin
        wc_n = wc + 2'd1;
        if (wc == 2'd3) begin
          state_n = CLEAR;
          valid_n = 1'b0;
          clr_n[oTag] = 1'b0;
        end else begin
          data_n = snap[wc_n*BITS +: BITS];
        end
      end
      CLEAR: begin
        state_n = HOLD;
        clr_n = '1;
      end
      HOLD: begin
        state_n = IDLE;
        en_n[oTag] = 1'b1;
        ptr_n = (oTag == TW'(NUM_LOG-1)) ? '0 : oTag + 1'b1;
        busy_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      ptr <= '0;
      wc <= '0;
      snap <= '0;
      oEnable <= '1;
      oClear_n <= '1;
      oData <= '0;
      oTag <= '0;
      oValid <= 1'b0;
      oBusy <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      wc <= wc_n;
      snap <= snap_n;
      oEnable <= en_n;
      oClear_n <= clr_n;
      oData <= data_n;
      oTag <= tag_n;
      oValid <= valid_n;
      oBusy <= busy_n;
    end
  end
endmodule
